// File: rtl/pipe_reg_pkg.sv
// Shared types and constants for the skid-buffered pipeline register.
package pipe_reg_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_slot.sv
// One data word plus its valid bit: load, drop (valid only), clear and reset to INITIAL_VALUE.
module pipe_slot
    import pipe_reg_pkg::*;
#(
    parameter int unsigned            WIDTH         = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]       INITIAL_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // Data is kept on drop so the output holds its last value while invalid.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q     <= INITIAL_VALUE;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with valid/ready handshake, two-entry skid buffer, flush and reset value.
// Optional stall counter enabled by defining PIPE_SKID_REG_STATS_EN.
module pipe_skid_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH         = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
`ifdef PIPE_SKID_REG_STATS_EN
    ,
    parameter int unsigned      CNT_WIDTH     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     din,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     dout
`ifdef PIPE_SKID_REG_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_count
`endif
);

    state_t           state_q, state_d;
    logic             accept, consume;
    logic             main_load, main_drop, skid_load, skid_drop;
    logic [WIDTH-1:0] main_d, skid_q;
    logic             skid_valid;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // State register; in_ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != SKID);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept && !consume)      state_d = SKID;
                else if (!accept && consume) state_d = EMPTY;
            end
            SKID:    if (consume) state_d = FULL;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // Slot control: main takes din when free or replaced, skid when it drains.
    always_comb begin
        main_load = 1'b0;
        main_drop = 1'b0;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        main_d    = din;
        case (state_q)
            EMPTY: main_load = accept;
            FULL: begin
                main_load = accept && consume;
                main_drop = !accept && consume;
                skid_load = accept && !consume;
            end
            SKID: begin
                main_d    = skid_q;
                main_load = consume && skid_valid;
                skid_drop = consume;
            end
            default: ;
        endcase
    end

    pipe_slot #(
        .WIDTH         (WIDTH),
        .INITIAL_VALUE (INITIAL_VALUE)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .load  (main_load),
        .drop  (main_drop),
        .d     (main_d),
        .valid (out_valid),
        .q     (dout)
    );

    pipe_slot #(
        .WIDTH         (WIDTH),
        .INITIAL_VALUE (INITIAL_VALUE)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .load  (skid_load),
        .drop  (skid_drop),
        .d     (din),
        .valid (skid_valid),
        .q     (skid_q)
    );

`ifdef PIPE_SKID_REG_STATS_EN
    // Saturating count of back-pressured cycles; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
